serial_sub32: RTL
=================

Name: serial_sub32

Overview:
- Multi-cycle 32-bit subtractor computing d = a - b, the inverse operation of the team's 32-bit ripple-carry adder.
- Reuses the same 4-bit slice arithmetic, but processes one nibble per clock through a single registered slice instead of chaining eight slices combinationally.
- Sits beside the adder in the ALU datapath wherever area matters more than latency.
- Uses a start/busy/done handshake toward the controlling FSM.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of NIB.
- NIB, 4, bits processed per cycle; the number of steps is STEPS = WIDTH/NIB (8 by default).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled on accepted start.
- b  input  WIDTH  subtrahend; sampled on accepted start.
- d  output  WIDTH  difference a - b (mod 2^WIDTH).
- bo  output  1  borrow out; 1 when unsigned a < b.
- ovf  output  1  signed overflow.
- zero  output  1  1 when d == 0.
- busy  output  1  high while RUN.
- done  output  1  one-cycle pulse when results become valid.

Behaviour:
- Reset (reset_n=0 at a rising edge) forces state IDLE and clears all outputs and internals to 0: d, bo, ovf, zero, busy, done, step counter, operand registers, carry.
- Reset has priority over everything, including a RUN in progress. The partial result is discarded and no done is issued.
- States:
  - IDLE -> RUN on start=1.
  - RUN -> DONE after STEPS nibbles.
  - DONE -> IDLE unconditionally after one cycle.
- Acceptance at edge T (IDLE, start=1):
  - Latch a and b into operand registers.
  - Set carry=1 (two's-complement +1), step=0, busy=1, and clear d.
- RUN, edge T+1+k for k = 0..STEPS-1:
  - Compute nibble k as {c, s} = a_nib(k) + ~b_nib(k) + carry.
  - Write s into d[NIB*k +: NIB]; carry <= c; step increments.
  - The adder slice is purely combinational; only carry and d are registered.
- At edge T+STEPS (last nibble written), state becomes DONE. In the same cycle:
  - busy=0, done=1.
  - bo = ~final carry.
  - ovf = (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]), using the latched operands.
  - zero = (d == 0).
- Edge T+STEPS+1: state returns to IDLE, done=0.
- d, bo, ovf and zero hold their values until the next accepted start. On acceptance, d, bo, ovf and zero clear to 0.
- Total latency: done is high in the cycle after edge T+STEPS. By default that is 8 cycles after acceptance; the next start is accepted at T+STEPS+2 at the earliest.
- start while RUN or DONE: ignored, with no queuing. start held high continuously causes back-to-back operations with one IDLE cycle between them.
- Changes on a or b after acceptance have no effect on the operation in flight.
- Inputs carrying X in IDLE with start=0 must not disturb any output.

Test Plan:
- Basic subtract, a=0x0000_0010, b=0x0000_0001, start pulse -> done exactly 8 cycles after acceptance; d=0x0000_000F, bo=0, ovf=0, zero=0; busy high for exactly 8 cycles.
- Borrow chain, a=0x0000_0000, b=0x0000_0001 -> d=0xFFFF_FFFF, bo=1, ovf=0, zero=0. This confirms the borrow ripples through all 8 nibbles.
- Zero and overflow, in two runs:
  - a=b=0x1234_5678 -> d=0, zero=1, bo=0.
  - a=0x8000_0000, b=0x0000_0001 -> d=0x7FFF_FFFF, ovf=1, bo=0.
- Handshake robustness:
  - start held high for 20 cycles with a=5, b=3 -> two completions with d=2 each, done pulses 10 cycles apart.
  - A change to a mid-RUN does not alter the result.
- Reset mid-operation: reset_n=0 at the 4th RUN cycle -> the next cycle has all outputs 0 and state IDLE, and no done pulse appears. A following start with a=7, b=9 yields d=0xFFFF_FFFE, bo=1.
- Randomized check: 1000 random a/b pairs against a reference model. Compare d, bo, ovf and zero, with signed overflow evaluated on 32-bit two's complement.

Source files
------------

// File: rtl/serial_sub32_if.sv
// Handshake and operand/result bundle between the ALU controller and serial_sub32.
interface serial_sub32_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] d;
  logic             bo;
  logic             ovf;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b,
    input  d, bo, ovf, zero, busy, done
  );

  modport slave (
    input  start, a, b,
    output d, bo, ovf, zero, busy, done
  );

endinterface

// File: rtl/serial_sub32.sv
// Nibble-serial subtractor: d = a - b, one NIB-wide slice per clock.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; results from the last operation held
// S_RUN  | one nibble of a + ~b + carry written into d per cycle
// S_DONE | one-cycle done pulse; d/bo/ovf/zero valid and held afterwards
module serial_sub32 #(
  parameter int WIDTH = 32,
  parameter int NIB   = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  serial_sub32_if.slave   bus
);

  localparam int STEPS = WIDTH / NIB;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] d_nxt;
  logic [SW-1:0]    step_q;
  logic             carry_q;
  logic             bo_q;
  logic             ovf_q;
  logic             zero_q;

  logic [NIB-1:0]   a_nib;
  logic [NIB-1:0]   b_nib;
  logic [NIB-1:0]   slice_s;
  logic             slice_c;

  // Single combinational slice: pick nibble `step` of each operand, add with
  // inverted subtrahend and running carry, and merge the sum into a copy of d.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < STEPS; i++) begin
      if (step_q == SW'(i)) begin
        a_nib = a_q[NIB*i +: NIB];
        b_nib = b_q[NIB*i +: NIB];
      end
    end
    {slice_c, slice_s} = {1'b0, a_nib} + {1'b0, ~b_nib} + {{NIB{1'b0}}, carry_q};
    d_nxt = d_q;
    for (int i = 0; i < STEPS; i++) begin
      if (step_q == SW'(i)) begin
        d_nxt[NIB*i +: NIB] = slice_s;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only looked at in IDLE, so no queuing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (step_q == LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, nibble stepping and result flags; flags are taken from
  // d_nxt on the last step so they are valid in the same cycle as done.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      step_q  <= '0;
      carry_q <= 1'b0;
      bo_q    <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            d_q     <= '0;
            step_q  <= '0;
            carry_q <= 1'b1;
            bo_q    <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
          end
        end
        S_RUN: begin
          d_q     <= d_nxt;
          carry_q <= slice_c;
          step_q  <= step_q + 1'b1;
          if (step_q == LAST) begin
            bo_q   <= ~slice_c;
            ovf_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_nxt[WIDTH-1] != a_q[WIDTH-1]);
            zero_q <= (d_nxt == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.d    = d_q;
  assign bus.bo   = bo_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;
  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);

endmodule
